// File: rtl/calcul_tile_sched.sv
// Tiled matmul sequencer: walks m/n/k tiles and issues opcodes to calcul via start/done.
// Latency: start one cycle after accept; next start or job_done one cycle after done.
// Backpressure: cmd_ready low while a job runs; each op waits on calc_done with a watchdog.
module calcul_tile_sched #(
    parameter int WIDTH_HEIGHT   = 16,
    parameter int MAX_MAT_WH     = 128,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int T             = MAX_MAT_WH / WIDTH_HEIGHT,
    localparam int TB            = (T > 1) ? $clog2(T) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [TB-1:0] cmd_tiles_m,
    input  logic [TB-1:0] cmd_tiles_k,
    input  logic [TB-1:0] cmd_tiles_n,
    input  logic          cmd_relu,
    output logic          calc_start,
    output logic [2:0]    calc_opcode,
    output logic [7:0]    calc_addr_1,
    output logic [TB-1:0] calc_submat_row,
    output logic [TB-1:0] calc_submat_col,
    input  logic          calc_done,
    output logic          busy,
    output logic          job_done,
    output logic          error
);

    localparam logic [2:0] OP_LOAD_W     = 3'd1;
    localparam logic [2:0] OP_LOAD_IN    = 3'd2;
    localparam logic [2:0] OP_MM_CLR     = 3'd3;
    localparam logic [2:0] OP_MM_ACC     = 3'd4;
    localparam logic [2:0] OP_DRAIN      = 3'd5;
    localparam logic [2:0] OP_DRAIN_RELU = 3'd6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [TB-1:0] mt_q, kt_q, nt_q;
    logic          relu_q;
    logic [TB-1:0] m, n, k;
    logic [1:0]    s;
    logic [WDW-1:0] wd;

    logic [TB-1:0] adv_m, adv_n, adv_k;
    logic [1:0]    adv_s;
    logic          last_op;
    logic [2:0]    nxt_op;
    logic [7:0]    nxt_addr;

    assign cmd_ready = (state == S_IDLE) || (state == S_ERROR);
    assign busy      = (state == S_ISSUE) || (state == S_WAIT);

    // Next position in the m/n/k/step walk after the current op completes
    always_comb begin
        adv_m = m;
        adv_n = n;
        adv_k = k;
        adv_s = s;
        case (s)
            2'd0: adv_s = 2'd1;
            2'd1: adv_s = 2'd2;
            2'd2: begin
                if (k != kt_q) begin
                    adv_k = k + TB'(1);
                    adv_s = 2'd0;
                end else begin
                    adv_s = 2'd3;
                end
            end
            default: begin
                adv_s = 2'd0;
                adv_k = '0;
                if (n == nt_q) begin
                    adv_n = '0;
                    adv_m = m + TB'(1);
                end else begin
                    adv_n = n + TB'(1);
                end
            end
        endcase
    end

    assign last_op = (s == 2'd3) && (m == mt_q) && (n == nt_q);

    // Opcode and buffer address of the op at the advanced position
    always_comb begin
        nxt_op   = OP_LOAD_W;
        nxt_addr = 8'd0;
        case (adv_s)
            2'd0: nxt_addr = 8'(adv_k) * 8'(T) + 8'(adv_n);
            2'd1: begin
                nxt_op   = OP_LOAD_IN;
                nxt_addr = 8'(T * T) + 8'(adv_m) * 8'(T) + 8'(adv_k);
            end
            2'd2: nxt_op = (adv_k == '0) ? OP_MM_CLR : OP_MM_ACC;
            default: nxt_op = relu_q ? OP_DRAIN_RELU : OP_DRAIN;
        endcase
    end

    // Control FSM, loop counters, watchdog and registered calcul command
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            mt_q            <= '0;
            kt_q            <= '0;
            nt_q            <= '0;
            relu_q          <= 1'b0;
            m               <= '0;
            n               <= '0;
            k               <= '0;
            s               <= 2'd0;
            wd              <= '0;
            calc_start      <= 1'b0;
            calc_opcode     <= 3'd0;
            calc_addr_1     <= 8'd0;
            calc_submat_row <= '0;
            calc_submat_col <= '0;
            job_done        <= 1'b0;
            error           <= 1'b0;
        end else begin
            calc_start <= 1'b0;
            job_done   <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (cmd_valid) begin
                        mt_q            <= cmd_tiles_m;
                        kt_q            <= cmd_tiles_k;
                        nt_q            <= cmd_tiles_n;
                        relu_q          <= cmd_relu;
                        m               <= '0;
                        n               <= '0;
                        k               <= '0;
                        s               <= 2'd0;
                        error           <= 1'b0;
                        // first op of every job is the weight load of tile (0,0), k=0
                        calc_opcode     <= OP_LOAD_W;
                        calc_addr_1     <= 8'd0;
                        calc_submat_row <= '0;
                        calc_submat_col <= '0;
                        calc_start      <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // done seen here belongs to the previous op (level done), so it is ignored
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (calc_done) begin
                        if (last_op) begin
                            job_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            m               <= adv_m;
                            n               <= adv_n;
                            k               <= adv_k;
                            s               <= adv_s;
                            calc_opcode     <= nxt_op;
                            calc_addr_1     <= nxt_addr;
                            calc_submat_row <= adv_m;
                            calc_submat_col <= adv_n;
                            calc_start      <= 1'b1;
                            state           <= S_ISSUE;
                        end
                    end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        error <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/calcul_tile_sched.md
# calcul_tile_sched

Command-level sequencer that runs a complete tiled matrix multiply on the `calcul` compute block. It accepts one job descriptor giving the M, K and N tile counts plus a ReLU flag. It then walks every output tile and every K-slice, issuing weight-load, input-load, multiply and drain opcodes to `calcul` over a start/done handshake. It sits between the host command interface and `calcul`, drives `calcul`'s start/opcode/addr_1/submat inputs, and guards each operation with a watchdog.

## Interface
- `WIDTH_HEIGHT`, 16: systolic array edge; one tile is WIDTH_HEIGHT×WIDTH_HEIGHT.
- `MAX_MAT_WH`, 128: max matrix edge. T = MAX_MAT_WH/WIDTH_HEIGHT tiles per edge; TB = $clog2(T).
- `TIMEOUT_CYCLES`, 4096: max cycles to wait for `calc_done`.
- `OP_LOAD_W`/`OP_LOAD_IN`/`OP_MM_CLR`/`OP_MM_ACC`/`OP_DRAIN`/`OP_DRAIN_RELU`, 3'd1..3'd6: opcode encodings.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `cmd_valid`  input  1  job descriptor valid.
- `cmd_ready`  output  1  high in IDLE or ERROR.
- `cmd_tiles_m`, `cmd_tiles_k`, `cmd_tiles_n`  input  TB each  tile count minus 1 (0 means 1 tile).
- `cmd_relu`  input  1  use OP_DRAIN_RELU instead of OP_DRAIN.
- `calc_start`  output  1  one-cycle pulse that launches one `calcul` operation.
- `calc_opcode`  output  3  operation opcode.
- `calc_addr_1`  output  8  buffer address for load operations.
- `calc_submat_row`, `calc_submat_col`  output  TB each  output tile coordinates (m, n).
- `calc_done`  input  1  `calcul` operation complete (pulse or level); sampled only in WAIT.
- `busy`  output  1  high in ISSUE or WAIT.
- `job_done`  output  1  one-cycle pulse when the last operation completes.
- `error`  output  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, ERROR.
- Descriptor registers hold Mt, Kt, Nt and relu. Loop counters m, n, k and step s (0..3).
- IDLE/ERROR: on cmd_valid&cmd_ready, latch the descriptor, clear m/n/k/s, clear `error`, go to ISSUE.
- Loop order: m outer, n middle, k inner. For each k, steps run in order:
  - s=0: OP_LOAD_W, addr = k*T+n.
  - s=1: OP_LOAD_IN, addr = T*T + m*T + k.
  - s=2: OP_MM_CLR if k==0, else OP_MM_ACC; addr 0.
- After s=2 with k==Kt, step s=3 issues OP_DRAIN, or OP_DRAIN_RELU if relu is set; addr 0.
- Addresses are zero-extended to 8 bits.
- submat_row/col = m/n for every operation.
- ISSUE: `calc_start`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Watchdog counts cycles spent in WAIT.
  - On `calc_done`, advance the counters and go to ISSUE. If the op just completed was the final DRAIN (m==Mt, n==Nt), go to IDLE and pulse `job_done` instead.
  - If the watchdog reaches TIMEOUT_CYCLES with no done: go to ERROR, set `error`=1, no `job_done`.
- Counter advance:
  - s: 0→1→2. From 2: if k<Kt, k++ and s=0; otherwise s=3.
  - From 3: s=0, k=0, then n++. If n wraps from Nt to 0, m++.
- `calc_opcode`, `calc_addr_1` and `calc_submat_*` are registered and stay stable from ISSUE through the end of WAIT.
- Total operations per job = (Mt+1)(Nt+1)(3(Kt+1)+1).
- cmd_valid outside IDLE/ERROR is ignored; the descriptor is not latched.

## Timing
- Reset (reset==0 at a clock edge) forces IDLE, clears all counters, and drives outputs 0 except `cmd_ready`=1. This applies mid-job: the job is abandoned and no `job_done` is produced.
- `calc_start` rises in the cycle after command acceptance.
- `calc_done` sampled high in WAIT at edge t: the next `calc_start` is high in cycle t+1, or `job_done` is high in cycle t+1 with `cmd_ready`=1.
- `calc_done` in the same cycle as `calc_start` (ISSUE) is ignored. A level done held across ISSUE is therefore not double-counted.
- Done and watchdog terminal count in the same cycle: done wins.
- Watchdog resets to 0 on every entry to WAIT.
- Back-to-back jobs: a new command may be accepted in the cycle `job_done` is high.

## Test plan
- Mt=Kt=Nt=0, relu=0, done returned 5 cycles after each start → exactly 4 starts with opcodes 1,2,3,5; addrs 0, 64, 0, 0; one `job_done`; `busy` low afterwards.
- Mt=0, Kt=2, Nt=1, relu=1 → 20 starts. Per output tile: W/IN/CLR, W/IN/ACC, W/IN/ACC, then 6. Second tile has col=1 and W addrs 1, 9, 17.
- Done tied high permanently, Mt=Kt=Nt=7 → 1600 starts, each exactly 2 cycles apart; final op is at (7,7); `job_done` once.
- Withhold done after the 2nd start, TIMEOUT_CYCLES=16 → ERROR entered 16 cycles into WAIT, `error`=1, `cmd_ready`=1. A new command clears `error` and restarts from (0,0).
- Assert reset low during WAIT of the 3rd operation → next cycle all outputs 0 and `cmd_ready`=1; a later late done pulse has no effect.
- cmd_valid held high during a job → no re-latch; the next job starts only after `job_done`.
